// File: rtl/ibuf_reader.sv
// Instruction-buffer reader: turns 4-slot FIFO packets into up to two issued instructions per cycle.
// Optional decoder-bubble counter is built only when IBUF_READER_BUBBLE_CNT_EN is defined.
module ibuf_reader #(
  parameter logic [31:0] RESET_PC  = 32'h1c000000,
  parameter int          PKT_WIDTH = 128
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic [31:0]          flush_pc,
  input  logic                 fifo_empty,
  input  logic [PKT_WIDTH-1:0] fifo_pop_data,
  output logic                 fifo_pop,
  input  logic                 dec_ready,
  output logic                 inst0_valid,
  output logic                 inst1_valid,
  output logic [31:0]          inst0,
  output logic [31:0]          inst1,
  output logic [31:0]          inst0_pc,
  output logic [31:0]          inst1_pc,
  output logic [31:0]          bubble_cnt
);

  logic [31:0] pc;
  logic [1:0]  off;
  logic [31:0] slot [4];
  logic        pair;
  logic        advance;
  logic [31:0] pc_step;

  assign off = pc[3:2];

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      slot[k] = fifo_pop_data[32*k +: 32];
    end
  end

  // The last slot of a packet is never paired with the next packet's first slot.
  assign pair    = (off != 2'd3);
  assign pc_step = pair ? 32'd8 : 32'd4;
  assign advance = (~inst0_valid | dec_ready) & ~fifo_empty & ~flush;

  // The packet is consumed when this advance reaches its last slot (off 2 or 3).
  assign fifo_pop = advance & off[1] & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_PC;
      inst0_valid <= 1'b0;
      inst1_valid <= 1'b0;
      inst0       <= '0;
      inst1       <= '0;
      inst0_pc    <= '0;
      inst1_pc    <= '0;
    end else if (flush) begin
      pc          <= flush_pc;
      inst0_valid <= 1'b0;
      inst1_valid <= 1'b0;
    end else if (advance) begin
      inst0_valid <= 1'b1;
      inst0       <= slot[off];
      inst0_pc    <= pc;
      inst1_valid <= pair;
      if (pair) begin
        inst1    <= slot[off + 2'd1];
        inst1_pc <= pc + 32'd4;
      end
      pc <= pc + pc_step;
    end else if (dec_ready && inst0_valid) begin
      inst0_valid <= 1'b0;
      inst1_valid <= 1'b0;
    end
  end

`ifdef IBUF_READER_BUBBLE_CNT_EN
  logic [31:0] bubble_q;

  // A bubble is a cycle where the decoder could take work but nothing is presented.
  always_ff @(posedge clk) begin
    if (rst) begin
      bubble_q <= '0;
    end else if (!flush && dec_ready && !inst0_valid) begin
      bubble_q <= bubble_q + 32'd1;
    end
  end

  assign bubble_cnt = bubble_q;
`else
  assign bubble_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_ibuf_reader.sv
// Self-checking bench for ibuf_reader: directed scenarios followed by randomized traffic against a packet-level model.
module tb_ibuf_reader;

  logic         clk;
  logic         rst;
  logic         flush;
  logic [31:0]  flush_pc;
  logic         fifo_empty;
  logic [127:0] fifo_pop_data;
  logic         fifo_pop;
  logic         dec_ready;
  logic         inst0_valid;
  logic         inst1_valid;
  logic [31:0]  inst0;
  logic [31:0]  inst1;
  logic [31:0]  inst0_pc;
  logic [31:0]  inst1_pc;
  logic [31:0]  bubble_cnt;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [31:0] m_pc;
  logic        m_v0, m_v1;
  logic [31:0] m_i0, m_i1, m_p0, m_p1;
  logic [31:0] m_bub;

  localparam logic [127:0] PKT1 = {32'hdddd0003, 32'hcccc0002, 32'hbbbb0001, 32'haaaa0000};
  localparam logic [127:0] PKT2 = {32'h44440003, 32'h33330002, 32'h22220001, 32'h11110000};

  ibuf_reader dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .flush_pc     (flush_pc),
    .fifo_empty   (fifo_empty),
    .fifo_pop_data(fifo_pop_data),
    .fifo_pop     (fifo_pop),
    .dec_ready    (dec_ready),
    .inst0_valid  (inst0_valid),
    .inst1_valid  (inst1_valid),
    .inst0        (inst0),
    .inst1        (inst1),
    .inst0_pc     (inst0_pc),
    .inst1_pc     (inst1_pc),
    .bubble_cnt   (bubble_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Slot index into the packet and how many instructions the packet can still supply (at most 2).
  function automatic int slot_index(input logic [31:0] pc);
    return int'((pc % 32'd16) / 32'd4);
  endfunction

  function automatic int issue_count(input logic [31:0] pc);
    int left;
    left = 4 - slot_index(pc);
    return (left < 2) ? left : 2;
  endfunction

  function automatic logic model_pop(input logic r, input logic f, input logic e, input logic rdy);
    if (r || f || e || (m_v0 && !rdy)) return 1'b0;
    return (slot_index(m_pc) + issue_count(m_pc)) == 4;
  endfunction

  task automatic model_update(input logic r, input logic f, input logic [31:0] fpc,
                              input logic e, input logic [127:0] data, input logic rdy);
    int idx, cnt;
    if (r) begin
      m_pc = 32'h1c000000;
      m_v0 = 0; m_v1 = 0;
      m_i0 = 0; m_i1 = 0; m_p0 = 0; m_p1 = 0;
      m_bub = 0;
      return;
    end
`ifdef IBUF_READER_BUBBLE_CNT_EN
    if (!f && rdy && !m_v0) m_bub = m_bub + 1;
`endif
    if (f) begin
      m_pc = fpc;
      m_v0 = 0; m_v1 = 0;
    end else if (!e && (!m_v0 || rdy)) begin
      idx  = slot_index(m_pc);
      cnt  = issue_count(m_pc);
      m_v0 = 1;
      m_i0 = data[idx*32 +: 32];
      m_p0 = m_pc;
      m_v1 = (cnt == 2);
      if (cnt == 2) begin
        m_i1 = data[(idx+1)*32 +: 32];
        m_p1 = m_pc + 4;
      end
      m_pc = m_pc + 32'(4 * cnt);
    end else if (rdy) begin
      m_v0 = 0; m_v1 = 0;
    end
  endtask

  task automatic checkOutput();
    check32("inst0_valid", {31'd0, inst0_valid}, {31'd0, m_v0});
    check32("inst1_valid", {31'd0, inst1_valid}, {31'd0, m_v1});
    if (m_v0) begin
      check32("inst0", inst0, m_i0);
      check32("inst0_pc", inst0_pc, m_p0);
    end
    if (m_v1) begin
      check32("inst1", inst1, m_i1);
      check32("inst1_pc", inst1_pc, m_p1);
    end
    check32("bubble_cnt", bubble_cnt, m_bub);
  endtask

  // One clock: drive at negedge, check the combinational pop, then check registered outputs after the edge.
  task automatic applyStimulus(input logic r, input logic f, input logic [31:0] fpc,
                               input logic e, input logic [127:0] data, input logic rdy);
    @(negedge clk);
    rst = r; flush = f; flush_pc = fpc; fifo_empty = e; fifo_pop_data = data; dec_ready = rdy;
    #1;
    check32("fifo_pop", {31'd0, fifo_pop}, {31'd0, model_pop(r, f, e, rdy)});
    @(posedge clk);
    model_update(r, f, fpc, e, data, rdy);
    #1;
    checkOutput();
  endtask

  initial begin
    rst = 1; flush = 0; flush_pc = 0; fifo_empty = 0; fifo_pop_data = PKT1; dec_ready = 1;
    m_pc = 0; m_v0 = 0; m_v1 = 0; m_i0 = 0; m_i1 = 0; m_p0 = 0; m_p1 = 0; m_bub = 0;

    // reset with a non-empty FIFO: no pop, all outputs zero
    applyStimulus(1, 0, 0, 0, PKT1, 1);
    applyStimulus(1, 1, 32'h12345678, 0, PKT1, 1);
    check32("rst_inst0", inst0, 32'd0);
    check32("rst_inst1", inst1, 32'd0);
    check32("rst_inst0_pc", inst0_pc, 32'd0);
    check32("rst_inst1_pc", inst1_pc, 32'd0);

    // empty FIFO with a ready decoder for 5 cycles
    repeat (5) applyStimulus(0, 0, 0, 1, PKT1, 1);
`ifdef IBUF_READER_BUBBLE_CNT_EN
    check32("bubble_after_5", bubble_cnt, 32'd5);
`else
    check32("bubble_after_5", bubble_cnt, 32'd0);
`endif

    // one packet issues as two pairs
    applyStimulus(0, 0, 0, 0, PKT1, 1);
    check32("pair0_inst0", inst0, 32'haaaa0000);
    check32("pair0_pc0", inst0_pc, 32'h1c000000);
    check32("pair0_inst1", inst1, 32'hbbbb0001);
    applyStimulus(0, 0, 0, 0, PKT1, 1);
    check32("pair1_inst0", inst0, 32'hcccc0002);
    check32("pair1_pc1", inst1_pc, 32'h1c00000c);

    // decoder stall: hold for 3 cycles
    repeat (3) applyStimulus(0, 0, 0, 0, PKT2, 0);
    check32("stall_hold_inst1", inst1, 32'hdddd0003);
    applyStimulus(0, 0, 0, 0, PKT2, 1);
    check32("after_stall_pc0", inst0_pc, 32'h1c000010);

    // flush into the last slot of a packet
    applyStimulus(0, 1, 32'h1c00000c, 0, PKT2, 1);
    applyStimulus(0, 0, 0, 0, PKT1, 1);
    check32("single_issue_inst0", inst0, 32'hdddd0003);
    check32("single_issue_v1", {31'd0, inst1_valid}, 32'd0);
    applyStimulus(0, 0, 0, 0, PKT2, 1);
    check32("next_pkt_off0", inst0, 32'h11110000);

    // flush colliding with a pop-eligible advance (pc at off 2)
    applyStimulus(0, 1, 32'hfffffff8, 0, PKT2, 1);
    check32("flush_v0", {31'd0, inst0_valid}, 32'd0);

    // PC wrap across the top of the address space
    applyStimulus(0, 0, 0, 0, PKT1, 1);
    check32("wrap_pc0", inst0_pc, 32'hfffffff8);
    check32("wrap_pc1", inst1_pc, 32'hfffffffc);
    applyStimulus(0, 0, 0, 0, PKT2, 1);
    check32("wrapped_pc0", inst0_pc, 32'h00000000);
    check32("wrapped_inst0", inst0, 32'h11110000);

    // flush during a stall discards held outputs
    applyStimulus(0, 0, 0, 0, PKT1, 0);
    applyStimulus(0, 1, 32'h1c000004, 0, PKT1, 0);
    check32("stall_flush_v0", {31'd0, inst0_valid}, 32'd0);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 99) < 2),
                    ($urandom_range(0, 99) < 6),
                    $urandom(),
                    ($urandom_range(0, 99) < 25),
                    {$urandom(), $urandom(), $urandom(), $urandom()},
                    ($urandom_range(0, 99) < 70));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ibuf_reader.md
IBUF_READER -- requirements
Module: ibuf_reader

Interface
REQ-001 The block SHALL have a parameter RESET_PC, default 32'h1c000000, giving the fetch PC loaded at reset.
REQ-002 The block SHALL have a parameter PKT_WIDTH, default 128, giving the packet width; it SHALL be fixed at four 32-bit instruction slots, with slot k at bits [32k+31:32k].
REQ-003 Port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 Port rst, input, 1: synchronous, active-high reset.
REQ-005 Port flush, input, 1: pipeline redirect.
REQ-006 Port flush_pc, input, 32: new PC, sampled when flush=1.
REQ-007 Port fifo_empty, input, 1: the instruction FIFO head is invalid.
REQ-008 Port fifo_pop_data, input, PKT_WIDTH: the FIFO head packet.
REQ-009 Port fifo_pop, output, 1: consumes the FIFO head this cycle.
REQ-010 Port dec_ready, input, 1: the decoder accepts all valid output slots this cycle.
REQ-011 Port inst0_valid / inst1_valid, outputs, 1 each: issue-slot valid flags.
REQ-012 Port inst0 / inst1, outputs, 32 each: issue-slot instructions.
REQ-013 Port inst0_pc / inst1_pc, outputs, 32 each: issue-slot PCs.
REQ-014 Port bubble_cnt, output, 32: decoder-bubble counter (see Configuration).

Function
REQ-015 The block SHALL keep a 32-bit PC register; the slot offset is off = pc[3:2].
REQ-016 Outputs SHALL be registered, giving 1-cycle latency from FIFO head to the decoder; out_valid = inst0_valid.
REQ-017 Advance SHALL be defined as advance = (~out_valid | dec_ready) & ~fifo_empty & ~flush.
REQ-018 On advance, slot 0 SHALL load inst0 = slot[off], inst0_pc = pc, inst0_valid = 1.
REQ-019 On advance with off<=2, slot 1 SHALL load inst1 = slot[off+1], inst1_pc = pc+4, inst1_valid = 1.
REQ-020 On advance with off==3, inst1_valid SHALL be 0; slots SHALL never pair instructions across packets.
REQ-021 Issue count n SHALL be 2 when off<=2 and 1 when off==3; on advance, pc SHALL become pc + 4n (32-bit wrap).
REQ-022 fifo_pop SHALL equal advance & (off+n == 4), i.e. off==2 or off==3; it SHALL never assert when fifo_empty=1.
REQ-023 When no advance occurs and dec_ready=1 with out_valid=1, both valid flags SHALL clear next cycle.
REQ-024 When no advance occurs and out_valid=1 with dec_ready=0, all outputs SHALL hold.
REQ-025 A packet entered with nonzero off SHALL skip slots below off.
REQ-026 Flush SHALL have priority over all other events: next cycle pc=flush_pc, inst0_valid=inst1_valid=0, and fifo_pop=0 in the flush cycle.
REQ-027 A flush during a decoder stall SHALL discard the held outputs.
REQ-028 fifo_pop SHALL be combinational from registered state and inputs; inst*/inst*_pc SHALL be don't-care when their valid flag is 0.

Reset
REQ-029 In any cycle with rst=1 the block SHALL set pc=RESET_PC, both valid flags to 0, inst0/inst1/inst0_pc/inst1_pc to 0, and bubble_cnt to 0.
REQ-030 fifo_pop SHALL be 0 while rst=1.
REQ-031 Reset SHALL have priority over flush.

Configuration
REQ-032 With macro IBUF_READER_BUBBLE_CNT_EN defined, bubble_cnt SHALL increment (wrapping at 2^32) each cycle with dec_ready=1, out_valid=0, rst=0 and flush=0.
REQ-033 With IBUF_READER_BUBBLE_CNT_EN undefined, bubble_cnt SHALL be constant 0 and no counter flops SHALL exist.

Verification
REQ-034 Reset, then one packet {D,C,B,A} (slot0=A), dec_ready=1 -> cycle 1: A@1c000000, B@1c000004; cycle 2: C@1c000008, D@1c00000c; fifo_pop=1 in the second advance cycle only.
REQ-035 flush with flush_pc=0x1c00000c, then packet {D,C,B,A} -> single issue D@1c00000c, inst1_valid=0, fifo_pop=1 in the same cycle; next packet starts at off=0.
REQ-036 dec_ready=0 for 3 cycles with outputs valid -> outputs stable, fifo_pop=0 and pc unchanged throughout.
REQ-037 flush asserted together with a pop-eligible advance -> fifo_pop=0, outputs invalid next cycle, pc=flush_pc.
REQ-038 fifo_empty=1 with dec_ready=1 for 5 cycles after reset -> valid flags 0; bubble_cnt=5 with IBUF_READER_BUBBLE_CNT_EN defined, 0 without.
REQ-039 pc=0xfffffff8 with a full packet -> issue at 0xfffffff8 and 0xfffffffc, then pc wraps to 0x00000000 with off=0.
